hwpe_stream_source_realign: RTL and testbench

- Load-side counterpart of the sink realigner. It takes word-aligned beats read from memory and produces a byte-realigned HWPE stream that starts at an arbitrary byte offset.
- Sits between a TCDM-facing source (stream_i) and the engine datapath (stream_o).
- Pass-through when realignment is off.
- When realignment is on, one primed word is held so that each output beat merges two consecutive input words.

---
 rtl/hwpe_stream_source_realign_pkg.sv | 19 +
 rtl/hwpe_stream_source_realign_if.sv | 13 +
 rtl/hwpe_stream_realign_merge.sv | 28 ++
 rtl/hwpe_stream_source_realign.sv | 107 ++++++++++
 tb/tb_hwpe_stream_source_realign.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/hwpe_stream_source_realign_pkg.sv
// Shared types for the load-side stream realigner: control word and FSM states.
package hwpe_stream_source_realign_pkg;

  typedef struct packed {
    logic enable;
    logic realign;
    logic first;
    logic last;
  } ctrl_realign_t;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } hwpe_stream_source_realign_state_t;

  localparam int unsigned BYTE_W = 8;

endpackage

// File: rtl/hwpe_stream_source_realign_if.sv
// HWPE valid/ready stream carrying one data word plus byte strobes per beat.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport master (output valid, data, strb, input  ready);
  modport slave  (input  valid, data, strb, output ready);
endinterface

// File: rtl/hwpe_stream_realign_merge.sv
// Two-word byte funnel: output byte j takes byte j+rot of the {cur, prev} pair.
module hwpe_stream_realign_merge #(
  parameter  int unsigned NB = 4,
  localparam int unsigned RW = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic [RW-1:0]         rot,
  input  logic [NB-1:0][7:0]    prev_data,
  input  logic [NB-1:0]         prev_strb,
  input  logic [NB-1:0][7:0]    cur_data,
  input  logic [NB-1:0]         cur_strb,
  output logic [NB-1:0][7:0]    data,
  output logic [NB-1:0]         strb
);
  localparam int unsigned IW = $clog2(2 * NB);

  logic [2*NB-1:0][7:0] cat_data;
  logic [2*NB-1:0]      cat_strb;

  assign cat_data = {cur_data, prev_data};
  assign cat_strb = {cur_strb, prev_strb};

  for (genvar j = 0; j < NB; j++) begin : g_byte
    logic [IW-1:0] idx;
    assign idx     = IW'(j) + IW'(rot);
    assign data[j] = cat_data[idx];
    assign strb[j] = cat_strb[idx];
  end
endmodule

// File: rtl/hwpe_stream_source_realign.sv
// Turns word-aligned memory beats into a stream starting at an arbitrary byte
// offset by holding one primed word and merging it with the next one.
module hwpe_stream_source_realign
  import hwpe_stream_source_realign_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   test_mode_i,
  input  ctrl_realign_t          ctrl_i,
  input  logic [STRB_WIDTH-1:0]  strb_i,
  hwpe_stream_intf_stream.slave  stream_i,
  hwpe_stream_intf_stream.master stream_o
);
  localparam int unsigned RW = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 1;

  hwpe_stream_source_realign_state_t state;

  logic [DATA_WIDTH-1:0] prev_data;
  logic [STRB_WIDTH-1:0] prev_strb;
  logic [RW-1:0]         rot;
  logic [RW-1:0]         r;
  logic [DATA_WIDTH-1:0] mrg_data;
  logic [STRB_WIDTH-1:0] mrg_strb;
  logic                  start;
  logic                  hs_in;
  logic                  unused;

  assign unused = test_mode_i;

  // Lowest set strobe bit gives the start offset; an empty mask reads as 0.
  always_comb begin
    r = '0;
    for (int i = STRB_WIDTH - 1; i >= 0; i--)
      if (strb_i[i]) r = RW'(i);
  end

  assign start = ctrl_i.enable & ctrl_i.realign & ctrl_i.first & (r != '0);
  assign hs_in = stream_i.valid & stream_i.ready;

  hwpe_stream_realign_merge #(.NB(STRB_WIDTH)) i_merge (
    .rot       (rot),
    .prev_data (prev_data),
    .prev_strb (prev_strb),
    .cur_data  (stream_i.data),
    .cur_strb  (stream_i.strb),
    .data      (mrg_data),
    .strb      (mrg_strb)
  );

  always_comb begin
    stream_o.valid = stream_i.valid;
    stream_o.data  = stream_i.data;
    stream_o.strb  = stream_i.strb;
    stream_i.ready = stream_o.ready;
    case (state)
      IDLE: if (start) begin
        stream_o.valid = 1'b0;
        stream_i.ready = 1'b0;
      end
      PRIME: begin
        stream_o.valid = 1'b0;
        stream_i.ready = 1'b1;
      end
      RUN: begin
        stream_o.data = mrg_data;
        stream_o.strb = mrg_strb;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      prev_data <= '0;
      prev_strb <= '0;
      rot       <= '0;
    end else if (clear_i) begin
      state     <= IDLE;
      prev_data <= '0;
      prev_strb <= '0;
      rot       <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= PRIME;
          rot   <= r;
        end
        PRIME: if (hs_in) begin
          prev_data <= stream_i.data;
          prev_strb <= stream_i.strb;
          state     <= RUN;
        end
        RUN: if (hs_in) begin
          prev_data <= stream_i.data;
          prev_strb <= stream_i.strb;
          if (ctrl_i.last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hwpe_stream_source_realign.sv
// Directed bench with a scoreboard of expected output beats for the source realigner.
module tb_hwpe_stream_source_realign;
  import hwpe_stream_source_realign_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          test_mode;
  ctrl_realign_t ctrl;
  logic [3:0]    strb_sel;

  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) s_in  ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) s_out ();

  hwpe_stream_source_realign #(.DATA_WIDTH(32)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clear),
    .test_mode_i (test_mode),
    .ctrl_i      (ctrl),
    .strb_i      (strb_sel),
    .stream_i    (s_in.slave),
    .stream_o    (s_out.master)
  );

  always #5 clk = ~clk;

  int          vecs = 0;
  int          errs = 0;
  logic [35:0] exp_q[$];
  bit          vld_rand = 1'b0;
  bit          rdy_rand = 1'b0;

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] expv);
    vecs++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) s_out.ready = rdy_rand ? 1'($urandom_range(1)) : 1'b1;

  // Output monitor: every accepted beat must match the head of the scoreboard.
  always begin
    @(negedge clk);
    #2;
    if (s_out.valid === 1'b1) chk("ready_follow", 36'(s_in.ready), 36'(s_out.ready));
    if (s_out.valid === 1'b1 && s_out.ready === 1'b1) begin
      vecs++;
      assert (exp_q.size() != 0) else begin
        errs++;
        $error("FAIL unexpected_out observed=%h expected=none", {s_out.strb, s_out.data});
      end
      if (exp_q.size() != 0) chk("out_beat", {s_out.strb, s_out.data}, exp_q.pop_front());
    end
  end

  task automatic start_burst(input logic [3:0] s);
    @(negedge clk);
    ctrl        = '{enable: 1'b1, realign: 1'b1, first: 1'b1, last: 1'b0};
    strb_sel    = s;
    s_in.valid  = 1'b0;
    s_in.data   = 'x;
    s_in.strb   = 'x;
    #1;
    chk("start_in_ready", 36'(s_in.ready), 36'd0);
    chk("start_out_valid", 36'(s_out.valid), 36'd0);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input logic last);
    bit done = 1'b0;
    int n = 0;
    while (!done) begin
      @(negedge clk);
      ctrl.first = 1'b0;
      ctrl.last  = last;
      if (vld_rand && $urandom_range(9) > 6) begin
        s_in.valid = 1'b0;
        s_in.data  = 'x;
        s_in.strb  = 'x;
      end else begin
        s_in.valid = 1'b1;
        s_in.data  = d;
        s_in.strb  = s;
        #1;
        done = s_in.ready;
      end
      n++;
      if (!done && n > 200) begin
        vecs++;
        assert (n <= 200) else begin
          errs++;
          $error("FAIL send_timeout observed=%0d cycles expected=handshake", n);
        end
        done = 1'b1;
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    s_in.valid = 1'b0;
    s_in.data  = 'x;
    s_in.strb  = 'x;
    ctrl       = '0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", 36'(exp_q.size()), 36'd0);
  endtask

  task automatic burst_r1();
    start_burst(4'b1110);
    exp_q.push_back({4'hF, 32'h04030201});
    exp_q.push_back({4'hF, 32'h08070605});
    send_beat(32'h03020100, 4'hF, 1'b0);
    send_beat(32'h07060504, 4'hF, 1'b0);
    send_beat(32'h0B0A0908, 4'hF, 1'b1);
    idle();
  endtask

  initial begin : wdog
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    clear      = 1'b0;
    test_mode  = 1'b0;
    ctrl       = '0;
    strb_sel   = 4'hF;
    s_in.valid = 1'b0;
    s_in.data  = '0;
    s_in.strb  = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_out_valid", 36'(s_out.valid), 36'd0);
    chk("reset_in_ready", 36'(s_in.ready), 36'(s_out.ready));
    @(negedge clk);
    rst_n = 1'b1;

    // Pass-through with realign off
    ctrl = '{enable: 1'b1, realign: 1'b0, first: 1'b0, last: 1'b0};
    exp_q.push_back({4'hF, 32'h03020100});
    exp_q.push_back({4'hF, 32'h07060504});
    send_beat(32'h03020100, 4'hF, 1'b0);
    send_beat(32'h07060504, 4'hF, 1'b0);
    idle();
    drain();

    burst_r1();
    drain();

    // r=3, last input strobe 0111 then 0011
    start_burst(4'b1000);
    exp_q.push_back({4'hF, 32'h06050403});
    send_beat(32'h03020100, 4'hF, 1'b0);
    send_beat(32'h07060504, 4'b0111, 1'b1);
    idle();
    drain();
    start_burst(4'b1000);
    exp_q.push_back({4'h7, 32'h06050403});
    send_beat(32'h03020100, 4'hF, 1'b0);
    send_beat(32'h07060504, 4'b0011, 1'b1);
    idle();
    drain();

    // Back-pressure on both sides
    vld_rand = 1'b1;
    rdy_rand = 1'b1;
    repeat (3) burst_r1();
    vld_rand = 1'b0;
    rdy_rand = 1'b0;
    drain();

    // Soft clear in the middle of a burst
    start_burst(4'b1110);
    exp_q.push_back({4'hF, 32'h04030201});
    send_beat(32'h03020100, 4'hF, 1'b0);
    send_beat(32'h07060504, 4'hF, 1'b0);
    @(negedge clk);
    s_in.valid = 1'b0;
    ctrl       = '0;
    clear      = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    ctrl  = '{enable: 1'b1, realign: 1'b0, first: 1'b0, last: 1'b0};
    exp_q.push_back({4'hF, 32'hDEADBEEF});
    send_beat(32'hDEADBEEF, 4'hF, 1'b0);
    idle();
    drain();

    // Async reset while primed, then a fresh r=2 burst
    start_burst(4'b0100);
    @(negedge clk);
    s_in.valid = 1'b0;
    ctrl       = '0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 36'(s_out.valid), 36'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_burst(4'b0100);
    exp_q.push_back({4'hF, 32'h05040302});
    send_beat(32'h03020100, 4'hF, 1'b0);
    send_beat(32'h07060504, 4'hF, 1'b1);
    idle();
    drain();

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
